code_entry_buffer: RTL

Parametrised keypad entry buffer for the safe lock controller. It accumulates digits from the keypad encoder into a right-aligned code word and supports variable code length, backspace, explicit or automatic submit, and an inter-key inactivity timeout. Its outputs feed the comparator and lockout FSM downstream.

---
 rtl/code_entry_buffer_pkg.sv | 25 ++
 rtl/code_entry_buffer_timer.sv | 48 ++++
 rtl/code_entry_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/code_entry_buffer_pkg.sv
// Shared types and width helpers for the safe lock keypad entry path.
package safe_lock_pkg;

    // Entry buffer states: empty, partially filled, full, and submitted/frozen.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ENTRY     = 2'd1,
        FULL      = 2'd2,
        SUBMITTED = 2'd3
    } entry_state_t;

    localparam int DIGIT_W_DEF    = 4;
    localparam int MAX_DIGITS_DEF = 6;

    // Width of a counter that must hold 0..max_digits inclusive.
    function automatic int cnt_width(input int max_digits);
        return $clog2(max_digits + 1);
    endfunction

    // Width of a counter that runs 0..cycles-1; never narrower than one bit.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/code_entry_buffer_timer.sv
// Inter-key inactivity timer. Runs while the entry is partially or fully
// populated, restarts on every accepted key and raises expire in the cycle
// the count sits on its last value. With TIMEOUT_CYCLES = 0 no counter is
// built and expire is constant zero.
module entry_timeout_timer
    import safe_lock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            // Inputs are intentionally not consumed when the timeout is disabled.
            logic w_unused;
            assign w_unused = ^{clk, rst, run, restart};
            assign expire   = 1'b0;
        end else begin : g_on
            localparam int            TW   = timer_width(TIMEOUT_CYCLES);
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

            logic [TW-1:0] r_cnt;
            logic          w_at_last;

            // expire does not look at restart: the FSM gives expiry priority
            // over keys, so a key in the expiry cycle is never accepted.
            assign w_at_last = (r_cnt == LAST);
            assign expire    = run && w_at_last;

            // Count idle cycles; hold at zero whenever the entry is not live.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (restart || !run || w_at_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + TW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/code_entry_buffer.sv
// Keypad entry buffer: collects digits right-aligned (newest in the LSBs),
// supports backspace, explicit or automatic submit, and discards the entry
// after a period of inactivity. All outputs are registered.
module code_entry_buffer
    import safe_lock_pkg::*;
#(
    parameter  int DIGIT_W        = DIGIT_W_DEF,
    parameter  int MAX_DIGITS     = MAX_DIGITS_DEF,
    parameter  int MIN_DIGITS     = 4,
    parameter  int AUTO_SUBMIT    = 0,
    parameter  int TIMEOUT_CYCLES = 50_000_000,
    localparam int CNT_W          = cnt_width(MAX_DIGITS),
    localparam int CODE_W         = MAX_DIGITS * DIGIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_entry,
    input  logic [DIGIT_W-1:0] code,
    input  logic              valid,
    input  logic              backspace,
    input  logic              enter,
    output logic [CODE_W-1:0] entered_code,
    output logic [CNT_W-1:0]  digit_count,
    output logic              done,
    output logic              reject,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_DIGITS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    entry_state_t      r_state;
    entry_state_t      w_state_next;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_done;
    logic              r_reject;
    logic              w_reject_next;
    logic              r_timeout;
    logic              w_timeout_next;

    logic [CODE_W-1:0] w_code_push;
    logic [CODE_W-1:0] w_code_pop;
    logic              w_run;
    logic              w_restart;
    logic              w_expire;

    // Digit lanes: push shifts every digit up one lane and inserts the new
    // key at lane 0; pop shifts every digit down one lane with zero fill.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign w_code_push[DIGIT_W-1:0] = code;
            end else begin : g_rest
                assign w_code_push[gi*DIGIT_W +: DIGIT_W] = r_code[(gi-1)*DIGIT_W +: DIGIT_W];
            end
            if (gi == MAX_DIGITS - 1) begin : g_top
                assign w_code_pop[gi*DIGIT_W +: DIGIT_W] = '0;
            end else begin : g_low
                assign w_code_pop[gi*DIGIT_W +: DIGIT_W] = r_code[(gi+1)*DIGIT_W +: DIGIT_W];
            end
        end
    endgenerate

    assign w_run = (r_state == ENTRY) || (r_state == FULL);

    entry_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (w_run),
        .restart (w_restart),
        .expire  (w_expire)
    );

    // Next-state logic: only the highest-priority strobe of the cycle is
    // acted on (clear > expiry > enter > backspace > valid).
    always_comb begin
        w_state_next   = r_state;
        w_code_next    = r_code;
        w_count_next   = r_count;
        w_reject_next  = 1'b0;
        w_timeout_next = 1'b0;
        w_restart      = 1'b0;

        if (clear_entry) begin
            w_state_next = IDLE;
            w_code_next  = '0;
            w_count_next = '0;
            w_restart    = 1'b1;
        end else if (w_expire) begin
            w_state_next   = IDLE;
            w_code_next    = '0;
            w_count_next   = '0;
            w_timeout_next = 1'b1;
        end else if (enter) begin
            case (r_state)
                ENTRY, FULL: begin
                    if (r_count >= MIN_CNT) begin
                        w_state_next = SUBMITTED;
                    end else begin
                        w_reject_next = 1'b1;
                    end
                end
                IDLE:    w_reject_next = 1'b1;
                default: ;
            endcase
        end else if (backspace) begin
            case (r_state)
                ENTRY, FULL: begin
                    w_code_next  = w_code_pop;
                    w_count_next = r_count - ONE_CNT;
                    w_restart    = 1'b1;
                    w_state_next = (r_count == ONE_CNT) ? IDLE : ENTRY;
                end
                IDLE:    w_reject_next = 1'b1;
                default: ;
            endcase
        end else if (valid) begin
            case (r_state)
                IDLE, ENTRY: begin
                    w_code_next  = w_code_push;
                    w_count_next = r_count + ONE_CNT;
                    w_restart    = 1'b1;
                    if (r_count + ONE_CNT == MAX_CNT) begin
                        w_state_next = (AUTO_SUBMIT != 0) ? SUBMITTED : FULL;
                    end else begin
                        w_state_next = ENTRY;
                    end
                end
                FULL:    w_reject_next = 1'b1;
                default: ;
            endcase
        end
    end

    // State and registered outputs; done mirrors the submitted state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_code    <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_code    <= w_code_next;
            r_count   <= w_count_next;
            r_done    <= (w_state_next == SUBMITTED);
            r_reject  <= w_reject_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign entered_code = r_code;
    assign digit_count  = r_count;
    assign done         = r_done;
    assign reject       = r_reject;
    assign timeout      = r_timeout;

endmodule
